// File: rtl/reg_file_sb_pkg.sv
// rf_pkg: shared types and default widths for the reg_file_sb register file.
//   rf_state_t - soft-clear engine states (IDLE, CLEAR, DONE)
//   RF_DATA_W  - default register width
//   RF_ADDR_W  - default address width
package rf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } rf_state_t;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;

endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: read, write, issue and clear signals of the register file.
//   master  - the requester side (decode/issue/writeback, or a testbench)
//   slave   - the register file itself
//   rsN_*   - two combinational read ports with pending-write flags
//   wr_*    - write port
//   issue_* - marks a destination as having an outstanding write
//   clear_* - soft-clear request and status
interface reg_file_sb_if
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);

  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              clear_req;
  logic              clear_busy;
  logic              clear_done;

  modport master (
    output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data,
           issue_en, issue_addr, clear_req,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, clear_busy, clear_done
  );

  modport slave (
    input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data,
           issue_en, issue_addr, clear_req,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, clear_busy, clear_done
  );

endinterface

// File: rtl/reg_file_sb_clear_fsm.sv
// rf_clear_fsm: sequential soft-clear engine. Walks idx over every register,
// requesting a zero write each cycle, then pulses clear_done once.
//   clk, rst   - clock, async active-high reset
//   clear_req  - start a clear (only honoured in IDLE)
//   clear_busy - engine owns the file (CLEAR or DONE)
//   clear_done - one-cycle pulse in DONE
//   clr_we     - zero-write request for clr_addr this cycle
//   clr_addr   - register being cleared
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  rf_state_t         state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          idx_nxt   = '0;
        end
      end
      CLEAR: begin
        // idx wraps to 0 on the last step, but the engine leaves CLEAR there
        idx_nxt = idx + ADDR_W'(1);
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clear_busy = (state == CLEAR) || (state == DONE);
    clear_done = (state == DONE);
    clr_we     = (state == CLEAR);
    clr_addr   = idx;
  end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with two combinational read ports, one write
// port (optional same-cycle bypass), a pending-write scoreboard and a
// sequential soft-clear engine.
//   clk, rst - clock, async active-high reset
//   bus      - reg_file_sb_if slave: read/write/issue/clear signals
// Parameters: DATA_W, ADDR_W (NUM_REGS = 2**ADDR_W), ZERO_REG (reg 0 hardwired
// to zero), BYPASS (read of the register being written returns wr_data).
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave bus
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam bit ZR       = (ZERO_REG != 0);
  localparam bit BP       = (BYPASS != 0);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;

  logic              clear_busy;
  logic              clear_done;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_accept;
  logic              issue_accept;
  logic              clear_start;
  logic              st_we;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;

  rf_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk       (clk),
    .rst       (rst),
    .clear_req (bus.clear_req),
    .clear_busy(clear_busy),
    .clear_done(clear_done),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // The engine is in IDLE exactly when clear_busy is low.
  assign wr_accept    = bus.wr_en && !clear_busy && !(ZR && bus.wr_addr == '0);
  assign issue_accept = bus.issue_en && !clear_busy && !(ZR && bus.issue_addr == '0);
  assign clear_start  = bus.clear_req && !clear_busy;

  // Clear engine and the external write port share one storage write port.
  assign st_we   = clr_we || wr_accept;
  assign st_addr = clr_we ? clr_addr : bus.wr_addr;
  assign st_data = clr_we ? '0 : bus.wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (st_we) begin
      regs[st_addr] <= st_data;
    end
  end

  // Issue is applied after write so a same-address pair leaves the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (clear_start) begin
      pending <= '0;
    end else begin
      if (wr_accept)    pending[bus.wr_addr]    <= 1'b0;
      if (issue_accept) pending[bus.issue_addr] <= 1'b1;
    end
  end

  always_comb begin
    bus.rs1_data = regs[bus.rs1_addr];
    if (BP && wr_accept && bus.wr_addr == bus.rs1_addr) bus.rs1_data = bus.wr_data;
    if (ZR && bus.rs1_addr == '0) bus.rs1_data = '0;
  end

  always_comb begin
    bus.rs2_data = regs[bus.rs2_addr];
    if (BP && wr_accept && bus.wr_addr == bus.rs2_addr) bus.rs2_data = bus.wr_data;
    if (ZR && bus.rs2_addr == '0) bus.rs2_data = '0;
  end

  assign bus.rs1_busy   = pending[bus.rs1_addr];
  assign bus.rs2_busy   = pending[bus.rs2_addr];
  assign bus.clear_busy = clear_busy;
  assign bus.clear_done = clear_done;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed checks of reg_file_sb. Three instances: default
// (16x16, bypass), no-bypass, and wide (32-bit x 32 regs).
module tb_reg_file_sb;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(16), .ADDR_W(4)) bus_a ();
  reg_file_sb_if #(.DATA_W(16), .ADDR_W(4)) bus_b ();
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_c ();

  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b));
  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_c (
    .clk(clk), .rst(rst), .bus(bus_c));

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        iss_en;
    logic [3:0]  iss_addr;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        eb1;
    logic        eb2;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse clear_req on bus_a (or bus_c when wide) and count busy/done cycles.
  // With inject set, a write/issue is attempted in the 5th busy cycle.
  task automatic run_clear(input bit wide, input bit inject,
                           output int busy_n, output int done_n);
    logic b, d;
    busy_n = 0;
    done_n = 0;
    @(negedge clk);
    if (wide) bus_c.clear_req = 1'b1; else bus_a.clear_req = 1'b1;
    @(negedge clk);
    bus_a.clear_req = 1'b0;
    bus_c.clear_req = 1'b0;
    for (int n = 0; n < 80; n++) begin
      bus_a.wr_en    = 1'b0;
      bus_a.issue_en = 1'b0;
      #1;
      b = wide ? bus_c.clear_busy : bus_a.clear_busy;
      d = wide ? bus_c.clear_done : bus_a.clear_done;
      if (b) busy_n++;
      if (d) done_n++;
      if (busy_n > 0 && !b) break;
      if (inject && b && busy_n == 5) begin
        bus_a.wr_en      = 1'b1;
        bus_a.wr_addr    = 4'd1;
        bus_a.wr_data    = 16'h7777;
        bus_a.issue_en   = 1'b1;
        bus_a.issue_addr = 4'd2;
        bus_a.rs1_addr   = 4'd1;
        #1;
        check("mid_clear_no_bypass", 32'(bus_a.rs1_data), 32'h0);
      end
      @(negedge clk);
    end
    bus_a.wr_en    = 1'b0;
    bus_a.issue_en = 1'b0;
  endtask

  task automatic check_all_zero_a(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus_a.rs1_addr = 4'(i);
      bus_a.rs2_addr = 4'(i);
      #1;
      check({tag, "_data"}, 32'(bus_a.rs1_data), 32'h0);
      check({tag, "_busy"}, {30'd0, bus_a.rs1_busy, bus_a.rs2_busy}, 32'h0);
    end
  endtask

  initial begin
    int busy_n, done_n;

    vecs[0]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd15, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd0, 16'hBEEF, 1'b0, 4'd0, 4'd0, 4'd0,  16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd1,  16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 4'd5, 4'd5,  16'h1234, 16'h1234, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd5, 4'd7,  16'h1234, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'd7, 16'h00AA, 1'b0, 4'd0, 4'd5, 4'd7,  16'h1234, 16'h00AA, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 4'd7, 16'h00AA, 1'b1, 4'd7, 4'd3, 4'd7,  16'h0000, 16'h00AA, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 4'd5, 4'd7,  16'h1234, 16'h00AA, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd0, 4'd7,  16'h0000, 16'h00AA, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 4'd9, 16'h5555, 1'b0, 4'd0, 4'd9, 4'd7,  16'h5555, 16'h00AA, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd9, 4'd3,  16'h5555, 16'h0000, 1'b0, 1'b0};

    rst = 1'b1;
    bus_a.rs1_addr = '0; bus_a.rs2_addr = '0; bus_a.wr_en = 1'b0; bus_a.wr_addr = '0;
    bus_a.wr_data = '0; bus_a.issue_en = 1'b0; bus_a.issue_addr = '0; bus_a.clear_req = 1'b0;
    bus_b.rs1_addr = '0; bus_b.rs2_addr = '0; bus_b.wr_en = 1'b0; bus_b.wr_addr = '0;
    bus_b.wr_data = '0; bus_b.issue_en = 1'b0; bus_b.issue_addr = '0; bus_b.clear_req = 1'b0;
    bus_c.rs1_addr = '0; bus_c.rs2_addr = '0; bus_c.wr_en = 1'b0; bus_c.wr_addr = '0;
    bus_c.wr_data = '0; bus_c.issue_en = 1'b0; bus_c.issue_addr = '0; bus_c.clear_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    #1;
    check("rst_clear_busy", 32'(bus_a.clear_busy), 32'h0);
    check("rst_clear_done", 32'(bus_a.clear_done), 32'h0);
    check_all_zero_a("rst");

    // Table-driven read/write/issue vectors on the bypass instance
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus_a.wr_en      = vecs[i].wr_en;
      bus_a.wr_addr    = vecs[i].wr_addr;
      bus_a.wr_data    = vecs[i].wr_data;
      bus_a.issue_en   = vecs[i].iss_en;
      bus_a.issue_addr = vecs[i].iss_addr;
      bus_a.rs1_addr   = vecs[i].ra1;
      bus_a.rs2_addr   = vecs[i].ra2;
      #1;
      check($sformatf("vec%0d_rs1_data", i), 32'(bus_a.rs1_data), 32'(vecs[i].e1));
      check($sformatf("vec%0d_rs2_data", i), 32'(bus_a.rs2_data), 32'(vecs[i].e2));
      check($sformatf("vec%0d_rs1_busy", i), 32'(bus_a.rs1_busy), 32'(vecs[i].eb1));
      check($sformatf("vec%0d_rs2_busy", i), 32'(bus_a.rs2_busy), 32'(vecs[i].eb2));
    end
    @(negedge clk);
    bus_a.wr_en = 1'b0;
    bus_a.issue_en = 1'b0;

    // No-bypass instance: old value in the write cycle, new value after
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 4'd5; bus_b.wr_data = 16'h1234; bus_b.rs1_addr = 4'd5;
    #1;
    check("nobyp_same_cycle", 32'(bus_b.rs1_data), 32'h0);
    @(negedge clk);
    bus_b.wr_en = 1'b0;
    #1;
    check("nobyp_next_cycle", 32'(bus_b.rs1_data), 32'h1234);

    // Fill every register, mark 3 and 9 pending, then clear with a dropped write
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus_a.wr_en = 1'b1; bus_a.wr_addr = 4'(i); bus_a.wr_data = 16'hFFFF;
    end
    @(negedge clk);
    bus_a.wr_en = 1'b0; bus_a.issue_en = 1'b1; bus_a.issue_addr = 4'd3;
    @(negedge clk);
    bus_a.issue_addr = 4'd9;
    @(negedge clk);
    bus_a.issue_en = 1'b0;
    bus_a.rs1_addr = 4'd3; bus_a.rs2_addr = 4'd9;
    #1;
    check("fill_busy3", 32'(bus_a.rs1_busy), 32'h1);
    check("fill_busy9", 32'(bus_a.rs2_busy), 32'h1);
    check("fill_data3", 32'(bus_a.rs1_data), 32'hFFFF);
    bus_a.rs1_addr = 4'd0;
    #1;
    check("fill_data0", 32'(bus_a.rs1_data), 32'h0);

    run_clear(1'b0, 1'b1, busy_n, done_n);
    check("clear16_busy_cycles", 32'(busy_n), 32'd17);
    check("clear16_done_pulses", 32'(done_n), 32'd1);
    check_all_zero_a("after_clear");

    // Reset five cycles into a clear
    @(negedge clk);
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 4'd12; bus_a.wr_data = 16'hABCD;
    @(negedge clk);
    bus_a.wr_en = 1'b0; bus_a.clear_req = 1'b1;
    @(negedge clk);
    bus_a.clear_req = 1'b0;
    busy_n = 0;
    done_n = 0;
    for (int n = 0; n < 5; n++) begin
      #1;
      if (bus_a.clear_busy) busy_n++;
      if (bus_a.clear_done) done_n++;
      @(negedge clk);
    end
    check("abort_busy_before_rst", 32'(busy_n), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("abort_busy_drops", 32'(bus_a.clear_busy), 32'h0);
    check("abort_no_done", 32'(bus_a.clear_done + 1'(done_n)), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_still_idle", 32'(bus_a.clear_busy), 32'h0);
    check_all_zero_a("after_abort");
    run_clear(1'b0, 1'b0, busy_n, done_n);
    check("reclear_busy_cycles", 32'(busy_n), 32'd17);
    check("reclear_done_pulses", 32'(done_n), 32'd1);

    // Wide instance: 32-bit data, 32 registers
    @(negedge clk);
    bus_c.wr_en = 1'b1; bus_c.wr_addr = 5'd31; bus_c.wr_data = 32'hDEADBEEF; bus_c.rs1_addr = 5'd31;
    #1;
    check("wide_bypass", bus_c.rs1_data, 32'hDEADBEEF);
    @(negedge clk);
    bus_c.wr_en = 1'b0;
    #1;
    check("wide_readback", bus_c.rs1_data, 32'hDEADBEEF);
    run_clear(1'b1, 1'b0, busy_n, done_n);
    check("wide_clear_busy_cycles", 32'(busy_n), 32'd33);
    check("wide_clear_done_pulses", 32'(done_n), 32'd1);
    #1;
    check("wide_after_clear", bus_c.rs1_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with combinational read ports, a write port with optional write-to-read bypass, a per-register pending-write scoreboard, and a sequential soft-clear engine. It is the next-generation general-purpose register file for the datapath. Decode and issue use the busy flags to stall on registers that still have an outstanding write, and the clear engine zeroes the file without asserting a global reset.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; NUM_REGS = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 always reads 0 and is never written or marked pending
- BYPASS, 1, 1 = a read of the address being written this cycle returns wr_data

Ports:
- clk  in  1  single clock; everything is rising-edge
- rst  in  1  asynchronous, active-high reset
- rs1_addr  in  ADDR_W  read port 1 address
- rs2_addr  in  ADDR_W  read port 2 address
- rs1_data  out  DATA_W  read port 1 data, combinational
- rs2_data  out  DATA_W  read port 2 data, combinational
- rs1_busy  out  1  pending bit of rs1_addr, combinational
- rs2_busy  out  1  pending bit of rs2_addr, combinational
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- issue_en  in  1  marks issue_addr pending (an outstanding write has been issued)
- issue_addr  in  ADDR_W  destination being issued
- clear_req  in  1  request a soft clear; sampled only in IDLE
- clear_busy  out  1  high while the clear engine owns the file
- clear_done  out  1  one-cycle pulse when a clear completes

## Operation
Storage and reset:
- Storage is NUM_REGS x DATA_W registers plus a NUM_REGS-bit pending vector.
- On rst, all registers and pending bits go to 0, the FSM goes to IDLE, and clear_busy = clear_done = 0.

Reads:
- rsN_data = 0 if ZERO_REG and rsN_addr == 0.
- Otherwise, if BYPASS and wr_accept and wr_addr == rsN_addr, rsN_data = wr_data.
- Otherwise, rsN_data = the stored value.
- rsN_busy = the pending bit, with no bypass (a same-cycle write does not hide busy).

Writes:
- wr_accept = wr_en & state == IDLE & !(ZERO_REG & wr_addr == 0).
- An accepted write updates the register and clears its pending bit at the next edge.

Issue:
- issue_accept = issue_en & state == IDLE & !(ZERO_REG & issue_addr == 0).
- An accepted issue sets the pending bit at the next edge.
- If an issue and a write hit the same address in the same cycle, the data is written and the pending bit ends set: the issue wins.
- Re-issuing an address that is already pending leaves it pending. There is no counting.

FSM, states IDLE, CLEAR, DONE:
- IDLE -> CLEAR on clear_req. At that edge all pending bits clear and idx <= 0.
- CLEAR: each cycle, register[idx] <= 0 and idx increments. When idx == NUM_REGS-1, go to DONE.
- DONE: clear_done = 1 for exactly one cycle, then return to IDLE.
- clear_busy = 1 in CLEAR and DONE.
- clear_req is ignored outside IDLE.
- wr_en and issue_en are dropped, not queued, while clear_busy = 1.
- Reads remain legal during a clear and return the current (partially cleared) contents.

Width:
- idx is ADDR_W bits and must not wrap before the DONE transition.
- Addresses are used unsigned and without truncation.
- No arithmetic is performed on the data.

## Timing
- Read latency: 0 cycles (combinational from address and storage).
- Write visible on read ports: the same cycle when BYPASS = 1, the next cycle otherwise.
- Busy set: the cycle after the issue edge. Busy clear: the cycle after the write edge.
- Clear duration: clear_busy rises the cycle after clear_req is sampled and stays high NUM_REGS + 1 cycles (NUM_REGS in CLEAR, 1 in DONE).
- clear_done pulses in the final cycle.
- A new clear_req is accepted the cycle after clear_busy falls.
- rst asserted mid-clear aborts immediately: IDLE, outputs 0, no clear_done pulse.

## Structure
- A shared package rf_pkg holds:
  - the state enumeration (IDLE, CLEAR, DONE)
  - the default-width constants RF_DATA_W = 16 and RF_ADDR_W = 4
- One sub-module is natural: rf_clear_fsm.
  - It owns the state register and idx counter.
  - Outputs: clear_busy, clear_done, clr_we, clr_addr.
  - The top level muxes clr_we/clr_addr ahead of the storage write port.
- Scoreboard, storage, and bypass stay in the top level.

## Test plan
- Reset then read all addresses: every rsN_data = 0 and rsN_busy = 0. Write 0xBEEF to reg 0 with ZERO_REG = 1: reg 0 still reads 0.
- Write 0x1234 to reg 5 and read rs1_addr = 5 in the same cycle:
  - BYPASS = 1 returns 0x1234 that cycle.
  - BYPASS = 0 returns the old value that cycle, then 0x1234 the next.
- Issue reg 7: rs2_busy = 1 the next cycle. Write 0x00AA to reg 7: busy = 0 the following cycle. Issue and write reg 7 in the same cycle: data 0x00AA and busy = 1.
- Fill every register with 0xFFFF, mark regs 3 and 9 pending, then pulse clear_req:
  - clear_busy stays high for 17 cycles (NUM_REGS = 16).
  - clear_done pulses once.
  - All registers read 0 and all busy flags are 0.
  - A write attempted mid-clear is dropped.
- Assert rst 5 cycles into a clear: clear_busy drops immediately, no clear_done pulse, all registers read 0. A subsequent clear_req is accepted normally.
- With DATA_W = 32 and ADDR_W = 5: write 0xDEADBEEF to reg 31 and read it back. A clear lasts 33 cycles.
